// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its bus interface.
package if_fetch_stage_pkg;

    localparam int unsigned STALL_W     = 6;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned BR_WD       = 33;
    localparam int unsigned IF_TO_ID_WD = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'hbfbf_fffc;

    typedef struct packed {
        logic              br_e;
        logic [ADDR_W-1:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic              ce;
        logic [ADDR_W-1:0] pc;
    } if_to_id_t;

    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: pipeline control in, decode/SRAM/exception signals out.
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  flush_pc;
    br_bus_t            br_bus;
    if_to_id_t          if_to_id_bus;
    logic               inst_sram_en;
    logic [3:0]         inst_sram_wen;
    logic [ADDR_W-1:0]  inst_sram_addr;
    logic [ADDR_W-1:0]  inst_sram_wdata;
    logic               if_excp;
    logic [ADDR_W-1:0]  if_badvaddr;

    modport master (
        input  stall, flush, flush_pc, br_bus,
        output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, if_excp, if_badvaddr
    );

    modport slave (
        output stall, flush, flush_pc, br_bus,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, if_excp, if_badvaddr
    );
endinterface

// File: rtl/if_fetch_stage_mmu_fetch.sv
// Fixed-mapping translation: kseg0/kseg1 fold onto low physical memory, all else passes through.
module mmu_fetch
    import if_fetch_stage_pkg::*;
(
    input  logic [ADDR_W-1:0] vaddr_i,
    output logic [ADDR_W-1:0] paddr_o
);
    always_comb begin
        paddr_o = vaddr_i;
        if (vaddr_i[31:29] == 3'b100 || vaddr_i[31:29] == 3'b101) begin
            paddr_o = {3'b000, vaddr_i[28:0]};
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC register, next-PC select with stalled-branch latch, SRAM request and AdEL flag.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_stage_if.master   bus
);
    br_bus_t           br;
    logic              adv_c;
    logic              next_mis_c;
    logic [ADDR_W-1:0] next_pc_c;
    logic [ADDR_W-1:0] paddr_c;
    logic              unused_stall;

    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              excp_q, excp_d;
    logic [ADDR_W-1:0] badv_q, badv_d;

    assign br           = bus.br_bus;
    assign unused_stall = ^bus.stall[STALL_W-1:1];
    assign adv_c        = bus.flush | (bus.stall[0] == NO_STOP);
    assign next_mis_c   = misaligned(next_pc_c);

    // Redirect priority: flush, live branch, latched branch, sequential
    always_comb begin
        next_pc_c = pc_q + ADDR_W'(4);
        if (bus.flush) begin
            next_pc_c = bus.flush_pc;
        end else if (br.br_e) begin
            next_pc_c = br.br_addr;
        end else if (pend_valid_q) begin
            next_pc_c = pend_addr_q;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        ce_d         = ce_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        excp_d       = excp_q;
        badv_d       = badv_q;
        if (adv_c) begin
            pc_d         = next_pc_c;
            ce_d         = 1'b1;
            pend_valid_d = 1'b0;
            excp_d       = next_mis_c;
            badv_d       = next_mis_c ? next_pc_c : '0;
        end else if (br.br_e) begin
            // Decode won't re-present the branch after a stall, so remember it
            pend_valid_d = 1'b1;
            pend_addr_d  = br.br_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            excp_q       <= 1'b0;
            badv_q       <= '0;
        end else begin
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            excp_q       <= excp_d;
            badv_q       <= badv_d;
        end
    end

    mmu_fetch u_mmu (
        .vaddr_i (next_pc_c),
        .paddr_o (paddr_c)
    );

    assign bus.if_to_id_bus    = '{ce: ce_q, pc: pc_q};
    assign bus.inst_sram_en    = ce_q & adv_c & ~next_mis_c;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = paddr_c;
    assign bus.inst_sram_wdata = '0;
    assign bus.if_excp         = excp_q;
    assign bus.if_badvaddr     = badv_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected post-edge state queued with each step, checked after the edge.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic        ce;
        logic [31:0] pc;
        logic        excp;
        logic [31:0] badv;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic ce, input logic [31:0] pc,
                                input logic excp, input logic [31:0] badv);
        exp_t e;
        e.tag = tag; e.ce = ce; e.pc = pc; e.excp = excp; e.badv = badv;
        sb.push_back(e);
    endtask

    // Advance one clock, then compare every registered output queued for this edge
    task automatic tick();
        exp_t      e;
        if_to_id_t o;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = bus.if_to_id_bus;
            chk({e.tag, ".ce"},    32'(o.ce),          32'(e.ce));
            chk({e.tag, ".pc"},    o.pc,               e.pc);
            chk({e.tag, ".excp"},  32'(bus.if_excp),   32'(e.excp));
            chk({e.tag, ".badv"},  bus.if_badvaddr,    e.badv);
        end
    endtask

    task automatic drive(input logic [5:0] stall, input logic br_e, input logic [31:0] br_addr,
                         input logic flush, input logic [31:0] flush_pc);
        bus.stall    = stall;
        bus.br_bus   = '{br_e: br_e, br_addr: br_addr};
        bus.flush    = flush;
        bus.flush_pc = flush_pc;
        #1;
    endtask

    task automatic comb(input string tag, input logic en, input logic [31:0] addr);
        chk({tag, ".en"},   32'(bus.inst_sram_en), 32'(en));
        chk({tag, ".addr"}, bus.inst_sram_addr,    addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            expect_state("reset", 1'b0, 32'hbfbf_fffc, 1'b0, 32'h0);
            tick();
        end
        comb("reset_en", 1'b0, 32'h1fc0_0000);
        chk("wen", 32'(bus.inst_sram_wen), 32'h0);
        chk("wdata", bus.inst_sram_wdata, 32'h0);

        // Release: ce rises, sequential fetch from the boot vector
        rst = 1'b0;
        #1;
        comb("release", 1'b0, 32'h1fc0_0000);
        expect_state("boot0", 1'b1, 32'hbfc0_0000, 1'b0, 32'h0);
        tick();
        comb("seq0", 1'b1, 32'h1fc0_0004);
        expect_state("boot1", 1'b1, 32'hbfc0_0004, 1'b0, 32'h0);
        tick();
        expect_state("boot2", 1'b1, 32'hbfc0_0008, 1'b0, 32'h0);
        tick();
        expect_state("seq3", 1'b1, 32'hbfc0_000c, 1'b0, 32'h0);
        tick();
        expect_state("seq4", 1'b1, 32'hbfc0_0010, 1'b0, 32'h0);
        tick();

        // Branch from pc bfc0_0010
        drive(6'b0, 1'b1, 32'hbfc0_0100, 1'b0, 32'h0);
        comb("branch", 1'b1, 32'h1fc0_0100);
        expect_state("branch", 1'b1, 32'hbfc0_0100, 1'b0, 32'h0);
        tick();

        // Branch arrives while stalled: latched, applied on release
        drive(6'b000001, 1'b1, 32'hbfc0_0200, 1'b0, 32'h0);
        comb("stall_br", 1'b0, 32'h1fc0_0200);
        expect_state("stall_hold0", 1'b1, 32'hbfc0_0100, 1'b0, 32'h0);
        tick();
        drive(6'b000001, 1'b0, 32'h0, 1'b0, 32'h0);
        comb("stall_pend", 1'b0, 32'h1fc0_0200);
        expect_state("stall_hold1", 1'b1, 32'hbfc0_0100, 1'b0, 32'h0);
        tick();
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        comb("pend_release", 1'b1, 32'h1fc0_0200);
        expect_state("pend_taken", 1'b1, 32'hbfc0_0200, 1'b0, 32'h0);
        tick();
        comb("pend_cleared", 1'b1, 32'h1fc0_0204);
        expect_state("after_pend", 1'b1, 32'hbfc0_0204, 1'b0, 32'h0);
        tick();

        // Flush beats stall and branch
        drive(6'b000011, 1'b1, 32'hbfc0_0300, 1'b1, 32'hbfc0_0380);
        comb("flush_prio", 1'b1, 32'h1fc0_0380);
        expect_state("flush_prio", 1'b1, 32'hbfc0_0380, 1'b0, 32'h0);
        tick();
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        comb("flush_nopend", 1'b1, 32'h1fc0_0384);

        // Misaligned branch target: no request, AdEL flagged next cycle
        drive(6'b0, 1'b1, 32'hbfc0_0402, 1'b0, 32'h0);
        comb("misalign", 1'b0, 32'h1fc0_0402);
        expect_state("misalign", 1'b1, 32'hbfc0_0402, 1'b1, 32'hbfc0_0402);
        tick();
        drive(6'b0, 1'b0, 32'h0, 1'b1, 32'hbfc0_0380);
        comb("excp_flush", 1'b1, 32'h1fc0_0380);
        expect_state("excp_clear", 1'b1, 32'hbfc0_0380, 1'b0, 32'h0);
        tick();

        // kseg0 translation
        drive(6'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0010);
        comb("kseg0", 1'b1, 32'h0000_0010);
        expect_state("kseg0", 1'b1, 32'h8000_0010, 1'b0, 32'h0);
        tick();

        // kuseg identity across a 64K boundary
        drive(6'b0, 1'b0, 32'h0, 1'b1, 32'h0000_fff8);
        expect_state("kuseg0", 1'b1, 32'h0000_fff8, 1'b0, 32'h0);
        tick();
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_state("kuseg1", 1'b1, 32'h0000_fffc, 1'b0, 32'h0);
        tick();
        comb("kuseg_ident", 1'b1, 32'h0001_0000);

        // PC wrap at the top of the address space
        drive(6'b0, 1'b0, 32'h0, 1'b1, 32'hffff_fff8);
        expect_state("wrap0", 1'b1, 32'hffff_fff8, 1'b0, 32'h0);
        tick();
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        comb("kseg3_ident", 1'b1, 32'hffff_fffc);
        expect_state("wrap1", 1'b1, 32'hffff_fffc, 1'b0, 32'h0);
        tick();
        comb("wrap", 1'b1, 32'h0000_0000);
        expect_state("wrap2", 1'b1, 32'h0000_0000, 1'b0, 32'h0);
        tick();

        // Reset while a branch is pending: the pending target is dropped
        drive(6'b000001, 1'b1, 32'hbfc0_0500, 1'b0, 32'h0);
        expect_state("pend_pre_rst", 1'b1, 32'h0000_0000, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_state("rst_mid", 1'b0, 32'hbfbf_fffc, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        comb("rst_pend_lost", 1'b0, 32'h1fc0_0000);
        expect_state("reboot", 1'b1, 32'hbfc0_0000, 1'b0, 32'h0);
        tick();
        comb("reboot_seq", 1'b1, 32'h1fc0_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
